aes_key_schedule_ctrl: RTL and testbench

- Iterative AES key-expansion controller for AES-128 and AES-256.
- Sequences the shared g_function datapath: RotWord, SubWord and Rcon XOR on the last word.
- Produces one 128-bit round key per accepted transfer, with a valid/ready handshake to the cipher round engine.
- Sits between the key register interface and the encryption core.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/AES_Sbox.sv | 29 ++
 rtl/g_function.sv | 25 ++
 rtl/sub_word.sv | 17 +
 rtl/aes_key_schedule_ctrl.sv | 114 +++++++++++
 tb/tb_aes_key_schedule_ctrl.sv | 278 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and Rcon stepping for the AES key-schedule controller.
package aes_pkg;

    localparam logic MODE_128 = 1'b0;
    localparam logic MODE_256 = 1'b1;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    localparam int LAST_RK_128 = 10;
    localparam int LAST_RK_256 = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Multiply by x in GF(2^8).
    function automatic logic [7:0] rcon_next(input logic [7:0] rcon);
        return {rcon[6:0], 1'b0} ^ (rcon[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/AES_Sbox.sv
// AES forward S-box as a constant lookup table.
module AES_Sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so index from the MSB end.
    assign subst = SBOX[{~value, 3'b000} +: 8];

endmodule

// File: rtl/g_function.sv
// Key-schedule g function: SubWord(RotWord(word)) xor {rcon, 24'h0}.
module g_function (
    input  logic [31:0] word,
    input  logic [7:0]  rcon,
    output logic [31:0] result
);

    logic [31:0] rotated;
    logic [31:0] substituted;

    assign rotated = {word[23:0], word[31:24]};

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_sbox
            AES_Sbox u_sbox (
                .value (rotated[8*b +: 8]),
                .subst (substituted[8*b +: 8])
            );
        end
    endgenerate

    assign result = substituted ^ {rcon, 24'h000000};

endmodule

// File: rtl/sub_word.sv
// SubWord: byte-wise S-box substitution of a 32-bit word, no rotation.
module sub_word (
    input  logic [31:0] word,
    output logic [31:0] result
);

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_sbox
            AES_Sbox u_sbox (
                .value (word[8*b +: 8]),
                .subst (result[8*b +: 8])
            );
        end
    endgenerate

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// Iterative AES-128/256 key expansion; emits one round key per valid/ready transfer.
module aes_key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int KEY_W = 256,
    parameter int RK_W  = 128,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             key_mode,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [IDX_W-1:0] rk_index,
    output logic [RK_W-1:0]  rk_data,
    output logic             done
);

    state_e           state;
    state_e           next_state;
    logic             mode;
    logic [RK_W-1:0]  cur;
    logic [RK_W-1:0]  prev;
    logic [RK_W-1:0]  base;
    logic [RK_W-1:0]  next_key;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] last_idx;
    logic [7:0]       rcon;
    logic [31:0]      g_out;
    logic [31:0]      sw_out;
    logic [31:0]      t;
    logic [31:0]      n0, n1, n2, n3;
    logic             uses_rcon;
    logic             advance_rcon;

    g_function u_g (
        .word   (cur[31:0]),
        .rcon   (rcon),
        .result (g_out)
    );

    sub_word u_sub (
        .word   (cur[31:0]),
        .result (sw_out)
    );

    assign last_idx = (mode == MODE_256) ? IDX_W'(LAST_RK_256) : IDX_W'(LAST_RK_128);
    assign rk_data  = cur;
    assign rk_index = idx;

    // AES-256 alternates g (next index even) and plain SubWord (next index odd);
    // the first generated key is simply the upper half of the cipher key.
    always_comb begin
        base         = (mode == MODE_256) ? prev : cur;
        t            = ((mode == MODE_256) && !idx[0]) ? sw_out : g_out;
        n0           = base[127:96] ^ t;
        n1           = n0 ^ base[95:64];
        n2           = n1 ^ base[63:32];
        n3           = n2 ^ base[31:0];
        next_key     = ((mode == MODE_256) && (idx == '0)) ? prev : {n0, n1, n2, n3};
        uses_rcon    = (mode == MODE_128) || idx[0];
        advance_rcon = uses_rcon && ((idx + IDX_W'(1)) != last_idx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        rk_valid   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) next_state = EMIT;
            EMIT: begin
                busy     = 1'b1;
                rk_valid = 1'b1;
                if (rk_ready && (idx == last_idx)) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode <= MODE_128;
            cur  <= '0;
            prev <= '0;
            idx  <= '0;
            rcon <= RCON_INIT;
        end else if ((state == IDLE) && start) begin
            mode <= key_mode;
            cur  <= key_in[KEY_W-1 -: RK_W];
            prev <= key_in[RK_W-1:0];
            idx  <= '0;
            rcon <= RCON_INIT;
        end else if ((state == EMIT) && rk_ready && (idx != last_idx)) begin
            cur <= next_key;
            if (mode == MODE_256) prev <= cur;
            idx <= idx + IDX_W'(1);
            if (advance_rcon) rcon <= rcon_next(rcon);
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Directed-vector bench for the AES key-schedule controller (FIPS-197 A.1 / A.3 keys).
module tb_aes_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         key_mode;
    logic [255:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_index;
    logic [127:0] rk_data;
    logic         done;

    aes_key_schedule_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_mode (key_mode),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_index (rk_index),
        .rk_data  (rk_data),
        .done     (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [255:0] key128;
    logic [255:0] key256;
    logic [127:0] exp128 [0:10];
    logic [127:0] exp256 [0:14];

    logic [127:0] cap_data [0:15];
    logic [3:0]   cap_idx  [0:15];
    int           cap_n;
    int           valid_cycles;
    int           first_valid;
    int           stall_viol;
    int           stalls;
    int           busy_viol;
    int           done_delay;
    bit           done_seen;

    // Drives one expansion and records every transfer plus handshake statistics.
    task automatic run_seq(input logic mode, input logic [255:0] key, input bit rnd, input bit poke);
        int           last_x = 0;
        bit           prev_stall = 0;
        bit           rdy;
        logic [127:0] hd = '0;
        logic [3:0]   hi = '0;
        cap_n = 0; valid_cycles = 0; first_valid = -1; stall_viol = 0;
        stalls = 0; busy_viol = 0; done_delay = -1; done_seen = 0;
        @(negedge clk);
        start = 1'b1; key_mode = mode; key_in = key; rk_ready = 1'b1;
        for (int cyc = 1; cyc <= 400 && !done_seen; cyc++) begin
            @(negedge clk);
            start = poke && (cyc == 3);
            if (poke && cyc == 3) begin
                key_in = ~key;
                key_mode = ~mode;
            end
            if (done) begin
                done_seen = 1;
                done_delay = cyc - last_x;
            end
            rdy = rnd ? (((cyc % 3) != 1) && ($urandom_range(0, 3) != 0)) : 1'b1;
            if (rk_valid) begin
                if (first_valid < 0) first_valid = cyc;
                valid_cycles++;
                if (!busy) busy_viol++;
                if (prev_stall && (rk_data !== hd || rk_index !== hi)) stall_viol++;
                if (rdy) begin
                    if (cap_n < 16) begin
                        cap_data[cap_n] = rk_data;
                        cap_idx[cap_n]  = rk_index;
                    end
                    cap_n++;
                    last_x = cyc;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    hd = rk_data;
                    hi = rk_index;
                    stalls++;
                end
            end
            rk_ready = rdy;
        end
        start = 1'b0;
        rk_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; key_mode = 1'b0; key_in = '0; rk_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (rk_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rk_valid); end
        tests++; if (rk_index !== 4'd0) begin fails++; $display("FAIL reset_index: got %0d want 0", rk_index); end
        tests++; if (rk_data !== '0)    begin fails++; $display("FAIL reset_data: got %h want 0", rk_data); end
        tests++; if (done !== 1'b0)     begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aes128();
        run_seq(1'b0, key128, 1'b0, 1'b0);
        tests++; if (!done_seen)        begin fails++; $display("FAIL a128_timeout: no done within bound"); end
        tests++; if (cap_n !== 11)      begin fails++; $display("FAIL a128_count: got %0d want 11", cap_n); end
        tests++; if (valid_cycles !== 11) begin fails++; $display("FAIL a128_valid_cycles: got %0d want 11", valid_cycles); end
        tests++; if (first_valid !== 1) begin fails++; $display("FAIL a128_latency: got %0d want 1", first_valid); end
        tests++; if (done_delay !== 1)  begin fails++; $display("FAIL a128_done_delay: got %0d want 1", done_delay); end
        tests++; if (busy_viol !== 0)   begin fails++; $display("FAIL a128_busy: got %0d want 0", busy_viol); end
        for (int i = 0; i < 11; i++) begin
            tests++;
            if (cap_data[i] !== exp128[i] || cap_idx[i] !== 4'(i)) begin
                fails++;
                $display("FAIL a128_rk%0d: got %0d/%h want %0d/%h", i, cap_idx[i], cap_data[i], i, exp128[i]);
            end
        end
        @(negedge clk);
        tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL a128_done_pulse: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_aes256();
        run_seq(1'b1, key256, 1'b0, 1'b0);
        tests++; if (!done_seen)        begin fails++; $display("FAIL a256_timeout: no done within bound"); end
        tests++; if (cap_n !== 15)      begin fails++; $display("FAIL a256_count: got %0d want 15", cap_n); end
        tests++; if (valid_cycles !== 15) begin fails++; $display("FAIL a256_valid_cycles: got %0d want 15", valid_cycles); end
        tests++; if (done_delay !== 1)  begin fails++; $display("FAIL a256_done_delay: got %0d want 1", done_delay); end
        for (int i = 0; i < 15; i++) begin
            tests++;
            if (cap_data[i] !== exp256[i] || cap_idx[i] !== 4'(i)) begin
                fails++;
                $display("FAIL a256_rk%0d: got %0d/%h want %0d/%h", i, cap_idx[i], cap_data[i], i, exp256[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        run_seq(1'b0, key128, 1'b1, 1'b0);
        tests++; if (!done_seen)      begin fails++; $display("FAIL bp_timeout: no done within bound"); end
        tests++; if (stalls == 0)     begin fails++; $display("FAIL bp_stalls: got 0 stalls want >0"); end
        tests++; if (stall_viol !== 0) begin fails++; $display("FAIL bp_stable: got %0d changes want 0", stall_viol); end
        tests++; if (cap_n !== 11)    begin fails++; $display("FAIL bp_count: got %0d want 11", cap_n); end
        for (int i = 0; i < 11; i++) begin
            tests++;
            if (cap_data[i] !== exp128[i] || cap_idx[i] !== 4'(i)) begin
                fails++;
                $display("FAIL bp_rk%0d: got %0d/%h want %0d/%h", i, cap_idx[i], cap_data[i], i, exp128[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        run_seq(1'b0, key128, 1'b0, 1'b1);
        tests++; if (cap_n !== 11) begin fails++; $display("FAIL swb_count: got %0d want 11", cap_n); end
        for (int i = 0; i < 11; i++) begin
            tests++;
            if (cap_data[i] !== exp128[i]) begin
                fails++;
                $display("FAIL swb_rk%0d: got %h want %h", i, cap_data[i], exp128[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_start_in_done();
        run_seq(1'b1, key256, 1'b0, 1'b0);
        tests++; if (!done_seen) begin fails++; $display("FAIL sid_timeout: no done within bound"); end
        start = 1'b1; key_mode = 1'b0; key_in = key128;
        @(negedge clk);
        start = 1'b0;
        tests++; if (rk_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL sid_ignored: got valid=%b busy=%b want 0 0", rk_valid, busy); end
        @(negedge clk);
        tests++; if (rk_valid !== 1'b0) begin fails++; $display("FAIL sid_idle: got valid=%b want 0", rk_valid); end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        int dsum = 0;
        @(negedge clk);
        start = 1'b1; key_mode = 1'b0; key_in = key128; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (rk_valid && rk_index == 4'd5) hit = 1;
            else @(negedge clk);
        end
        tests++; if (!hit) begin fails++; $display("FAIL rst_mid_reach: index 5 not reached"); end
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_index !== 4'd0 || rk_data !== '0 || done !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got busy=%b valid=%b idx=%0d data=%h done=%b want all 0", busy, rk_valid, rk_index, rk_data, done);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            dsum += int'(done);
        end
        tests++; if (dsum !== 0) begin fails++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", dsum); end
        run_seq(1'b0, key128, 1'b0, 1'b0);
        tests++; if (cap_n !== 11) begin fails++; $display("FAIL rst_mid_count: got %0d want 11", cap_n); end
        for (int i = 0; i < 11; i++) begin
            tests++;
            if (cap_data[i] !== exp128[i]) begin
                fails++;
                $display("FAIL rst_mid_rk%0d: got %h want %h", i, cap_data[i], exp128[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_seq(1'b1, key256, 1'b0, 1'b0);
        tests++; if (first_valid !== 1) begin fails++; $display("FAIL b2b_latency: got %0d want 1", first_valid); end
        tests++; if (cap_n !== 15)      begin fails++; $display("FAIL b2b_count: got %0d want 15", cap_n); end
        for (int i = 0; i < 15; i++) begin
            tests++;
            if (cap_data[i] !== exp256[i]) begin
                fails++;
                $display("FAIL b2b_rk%0d: got %h want %h", i, cap_data[i], exp256[i]);
            end
        end
    endtask

    initial begin
        key128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        exp256[0]  = 128'h603deb1015ca71be2b73aef0857d7781;
        exp256[1]  = 128'h1f352c073b6108d72d9810a30914dff4;
        exp256[2]  = 128'h9ba354118e6925afa51a8b5f2067fcde;
        exp256[3]  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
        exp256[4]  = 128'hd59aecb85bf3c917fee94248de8ebe96;
        exp256[5]  = 128'hb5a9328a2678a647983122292f6c79b3;
        exp256[6]  = 128'h812c81addadf48ba24360af2fab8b464;
        exp256[7]  = 128'h98c5bfc9bebd198e268c3ba709e04214;
        exp256[8]  = 128'h68007bacb2df331696e939e46c518d80;
        exp256[9]  = 128'hc814e20476a9fb8a5025c02d59c58239;
        exp256[10] = 128'hde1369676ccc5a71fa2563959674ee15;
        exp256[11] = 128'h5886ca5d2e2f31d77e0af1fa27cf73c3;
        exp256[12] = 128'h749c47ab18501ddae2757e4f7401905a;
        exp256[13] = 128'hcafaaae3e4d59b349adf6acebd10190d;
        exp256[14] = 128'hfe4890d1e6188d0b046df344706c631e;

        test_reset();
        test_aes128();
        test_aes256();
        test_backpressure();
        test_start_while_busy();
        test_start_in_done();
        test_reset_mid();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
